// File: rtl/cache_refill_axi.sv
// Miss-handling engine: optional victim write-back, then line refill over AXI4.
// One miss at a time; the write-back fully retires before the refill read issues.
module cache_refill_axi #(
  parameter int LINE_WORDS      = 16,
  parameter int CACHELINE_WIDTH = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_req,
  input  logic [31:0]                miss_addr,
  input  logic                       victim_dirty,
  input  logic [31:0]                victim_addr,
  output logic                       write_back,
  input  logic [CACHELINE_WIDTH-1:0] cacheline_old,
  output logic                       refresh,
  output logic [CACHELINE_WIDTH-1:0] cacheline_new,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [31:0]                rdata,
  input  logic                       rvalid,
  input  logic                       rlast,
  input  logic [1:0]                 rresp,
  output logic                       rready,
  output logic [31:0]                awaddr,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [31:0]                wdata,
  output logic [3:0]                 wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic                       bvalid,
  input  logic [1:0]                 bresp,
  output logic                       bready
);

  localparam int            BW   = $clog2(LINE_WORDS);
  localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);
  localparam logic [7:0]    LEN  = 8'(LINE_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WB_RD,
    S_WB_CAP,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_REFILL
  } state_t;

  state_t                     state, state_n;
  logic [BW-1:0]              beat, beat_n;
  logic [31:0]                miss_line, victim_line;
  logic [CACHELINE_WIDTH-1:0] wb_buf, line_q;

  // The beat counter alone ends a burst, so these are never consulted.
  logic unused_ok;
  assign unused_ok = ^{rlast, rresp, bresp,
                       miss_addr[5:0], victim_addr[5:0]};

  assign cacheline_new = line_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      beat        <= '0;
      miss_line   <= '0;
      victim_line <= '0;
      wb_buf      <= '0;
      line_q      <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
      if (state == S_IDLE && miss_req) begin
        miss_line   <= {miss_addr[31:6], 6'b0};
        victim_line <= {victim_addr[31:6], 6'b0};
      end
      if (state == S_WB_CAP)
        wb_buf <= cacheline_old;
      if (state == S_R && rvalid)
        line_q[beat*32 +: 32] <= rdata;
    end
  end

  always_comb begin
    state_n    = state;
    beat_n     = beat;
    busy       = (state != S_IDLE);
    write_back = 1'b0;
    refresh    = 1'b0;
    done       = 1'b0;
    araddr     = '0;
    arlen      = '0;
    arsize     = '0;
    arburst    = '0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awaddr     = '0;
    awlen      = '0;
    awsize     = '0;
    awburst    = '0;
    awvalid    = 1'b0;
    wdata      = '0;
    wstrb      = '0;
    wlast      = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (miss_req)
          state_n = victim_dirty ? S_WB_RD : S_AR;
      end
      S_WB_RD: begin
        write_back = 1'b1;
        state_n    = S_WB_CAP;
      end
      S_WB_CAP: begin
        state_n = S_AW;
      end
      S_AW: begin
        awvalid = 1'b1;
        awaddr  = victim_line;
        awlen   = LEN;
        awsize  = 3'd2;
        awburst = 2'b01;
        if (awready) begin
          state_n = S_W;
          beat_n  = '0;
        end
      end
      S_W: begin
        wvalid = 1'b1;
        wdata  = wb_buf[beat*32 +: 32];
        wstrb  = 4'hF;
        wlast  = (beat == LAST);
        if (wready) begin
          beat_n = beat + 1'b1;
          if (beat == LAST)
            state_n = S_B;
        end
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid)
          state_n = S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        araddr  = miss_line;
        arlen   = LEN;
        arsize  = 3'd2;
        arburst = 2'b01;
        if (arready) begin
          state_n = S_R;
          beat_n  = '0;
        end
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          beat_n = beat + 1'b1;
          if (beat == LAST)
            state_n = S_REFILL;
        end
      end
      S_REFILL: begin
        refresh = 1'b1;
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_refill_axi.sv
// Scoreboard bench for cache_refill_axi: memory-level reference model,
// AXI slave with selectable backpressure, monitor-side checking.
module tb_cache_refill_axi;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         miss_req, victim_dirty;
  logic [31:0]  miss_addr, victim_addr;
  logic         write_back, refresh, busy, done;
  logic [511:0] cacheline_old, cacheline_new;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rvalid, rlast, rready;
  logic         awvalid, awready, wvalid, wready, wlast;
  logic [3:0]   wstrb;
  logic         bvalid, bready;

  always #5 clk = ~clk;

  cache_refill_axi dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .write_back(write_back), .cacheline_old(cacheline_old),
    .refresh(refresh), .cacheline_new(cacheline_new),
    .busy(busy), .done(done),
    .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
    .rresp(rresp), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [511:0] line;
    int           lat;
    int           wbs;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_w_q[$];

  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];

  int           bp_mode = 0;
  int           rlast_mode = 0;
  logic [511:0] cur_victim = '0;

  // monitor -> slave handshake records
  logic        hs_ar = 0, hs_r = 0, hs_aw = 0, hs_w = 0, hs_b = 0, hs_wbk = 0;
  logic [31:0] rec_araddr = 0, rec_awaddr = 0, rec_wdata = 0;
  int          w_total = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
  endfunction

  function automatic logic [511:0] rnd_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic rdy(input int cnt);
    if (bp_mode == 0) return 1'b1;
    if (bp_mode == 1) return cnt > 3;
    return ($urandom % 3) != 0;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int           ncyc = 0, req_mark = 0, wbc = 0, mon_wbeat = 0;
  logic         wb_out = 0;
  logic [511:0] last_line = '0;
  logic         p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0;
  logic         p_wv = 0, p_wr = 0, p_wl = 0;
  logic [31:0]  p_araddr = 0, p_awaddr = 0, p_wdata = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0; hs_wbk = 0;
        wbc = 0; wb_out = 0; mon_wbeat = 0; last_line = '0;
        p_arv = 0; p_awv = 0; p_wv = 0;
      end else begin
        hs_ar = arvalid && arready;
        hs_r  = rvalid && rready;
        hs_aw = awvalid && awready;
        hs_w  = wvalid && wready;
        hs_b  = bvalid && bready;
        hs_wbk = write_back;
        rec_araddr = araddr;
        rec_awaddr = awaddr;
        rec_wdata  = wdata;
        if (miss_req && !busy) begin
          req_mark = ncyc;
          wbc = 0;
        end
        if (write_back) begin
          wbc++;
          wb_out = 1;
        end
        chk("done_eq_refresh", 512'(done), 512'(refresh));
        if (p_arv && !p_arr)
          chk("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
        if (p_awv && !p_awr)
          chk("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
        if (p_wv && !p_wr)
          chk("w_stable", {wvalid, wlast, wdata}, {1'b1, p_wl, p_wdata});
        if (!arvalid)
          chk("ar_idle_zero", {araddr, arlen, arsize, arburst}, '0);
        if (!awvalid)
          chk("aw_idle_zero", {awaddr, awlen, awsize, awburst}, '0);
        if (arvalid)
          chk("ar_before_b", 512'(wb_out), '0);
        if (hs_aw) begin
          mon_wbeat = 0;
          if (exp_aw_q.size() == 0) chk("unexpected_aw", 1, 0);
          else chk("awaddr", awaddr, exp_aw_q.pop_front());
          chk("aw_ctl", {awlen, awsize, awburst}, {8'd15, 3'd2, 2'b01});
        end
        if (hs_w) begin
          if (exp_w_q.size() == 0) chk("unexpected_w", 1, 0);
          else chk("wdata", wdata, exp_w_q.pop_front());
          chk("wlast", 512'(wlast), 512'(mon_wbeat == 15));
          chk("wstrb", wstrb, 4'hF);
          mon_wbeat++;
          w_total++;
        end
        if (hs_b) wb_out = 0;
        if (hs_ar) begin
          if (exp_ar_q.size() == 0) chk("unexpected_ar", 1, 0);
          else chk("araddr", araddr, exp_ar_q.pop_front());
          chk("ar_ctl", {arlen, arsize, arburst}, {8'd15, 3'd2, 2'b01});
        end
        if (refresh) begin
          if (exp_q.size() == 0) chk("unexpected_refresh", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("line", cacheline_new, e.line);
            chk("wb_pulses", wbc, e.wbs);
            if (e.lat >= 0) chk("latency", ncyc - req_mark, e.lat);
            last_line = e.line;
          end
        end else if (!busy) begin
          chk("line_hold", cacheline_new, last_line);
        end
        p_arv = arvalid; p_arr = arready; p_araddr = araddr;
        p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
        p_wv = wvalid; p_wr = wready; p_wl = wlast; p_wdata = wdata;
      end
    end
  end

  // ---------------- AXI slave + data array model ----------------
  logic        r_act = 0, b_pend = 0, rtog = 0;
  int          r_idx = 0, w_idx = 0, ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] r_base = 0, w_base = 0;

  initial begin
    arready = 0; rvalid = 0; rdata = 0; rlast = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    cacheline_old = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        r_act = 0; b_pend = 0; r_idx = 0; w_idx = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        arready = 0; rvalid = 0; rlast = 0; awready = 0;
        wready = 0; bvalid = 0;
        cacheline_old = rnd_line();
      end else begin
        if (hs_ar) begin r_act = 1; r_idx = 0; r_base = rec_araddr; end
        if (hs_r) begin r_idx++; if (r_idx >= 16) r_act = 0; end
        if (hs_aw) begin w_base = rec_awaddr; w_idx = 0; end
        if (hs_w) begin
          slv_mem[w_base + 32'(4*w_idx)] = rec_wdata;
          w_idx++;
          if (w_idx == 16) b_pend = 1;
        end
        if (hs_b) b_pend = 0;
        ar_cnt = arvalid ? ar_cnt + 1 : 0;
        aw_cnt = awvalid ? aw_cnt + 1 : 0;
        w_cnt  = hs_w ? 1 : (wvalid ? w_cnt + 1 : 0);
        arready = rdy(ar_cnt);
        awready = rdy(aw_cnt);
        wready  = rdy(w_cnt);
        rtog = ~rtog;
        if (!r_act) rvalid = 0;
        else if (bp_mode == 0) rvalid = 1;
        else if (bp_mode == 1) rvalid = rtog;
        else rvalid = ($urandom % 2) != 0;
        rdata = rvalid ? slv_rd(r_base + 32'(4*r_idx)) : $urandom;
        rlast = rvalid && ((rlast_mode == 0) ? (r_idx == 15) :
                           (rlast_mode == 1) ? (r_idx == 7) : 1'b0);
        rresp = 2'($urandom);
        bvalid = b_pend && (bp_mode != 2 || ($urandom % 2) != 0);
        bresp = 2'($urandom);
        cacheline_old = hs_wbk ? cur_victim : rnd_line();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic flush_exp();
    exp_q.delete(); exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete();
  endtask

  task automatic start_miss(input logic [31:0] ma, input logic [31:0] va,
                            input logic dirty, input logic [511:0] vd,
                            input logic lat_chk);
    exp_t        e;
    logic [31:0] ml, vl;
    ml = {ma[31:6], 6'b0};
    vl = {va[31:6], 6'b0};
    if (dirty) begin
      exp_aw_q.push_back(vl);
      for (int i = 0; i < 16; i++) begin
        exp_w_q.push_back(vd[i*32 +: 32]);
        ref_mem[vl + 32'(4*i)] = vd[i*32 +: 32];
      end
    end
    exp_ar_q.push_back(ml);
    for (int i = 0; i < 16; i++) e.line[i*32 +: 32] = ref_rd(ml + 32'(4*i));
    e.lat = lat_chk ? (dirty ? 38 : 18) : -1;
    e.wbs = dirty ? 1 : 0;
    exp_q.push_back(e);
    cur_victim = vd;
    miss_req = 1; miss_addr = ma; victim_addr = va; victim_dirty = dirty;
    @(posedge clk);
    #1;
    miss_req = 0; miss_addr = $urandom; victim_addr = $urandom;
    victim_dirty = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    flush_exp();
    rst = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 2000) begin
      chk("timeout", 1, 0);
      do_reset();
    end
  endtask

  task automatic run_miss(input logic [31:0] ma, input logic [31:0] va,
                          input logic dirty, input logic [511:0] vd,
                          input logic lat_chk);
    start_miss(ma, va, dirty, vd, lat_chk);
    wait_done();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctl"}, {arvalid, awvalid, wvalid, rready, bready,
                        write_back, refresh, done, busy}, '0);
    chk({tag, "_ar"}, {araddr, arlen, arsize, arburst}, '0);
    chk({tag, "_aw"}, {awaddr, awlen, awsize, awburst}, '0);
    chk({tag, "_line"}, cacheline_new, '0);
  endtask

  logic [511:0] vb;

  initial begin
    int tgt, t;
    miss_req = 0; miss_addr = 0; victim_addr = 0; victim_dirty = 0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[32'h1FC0_0100 + 32'(4*i)] = 32'hA000_0000 + 32'(i);
      slv_mem[32'h1FC0_0100 + 32'(4*i)] = 32'hA000_0000 + 32'(i);
      vb[i*32 +: 32] = 32'hB0 + 32'(i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;
    rst = 0;

    // zero-wait clean and dirty misses, then read back the written victim
    run_miss(32'h1FC0_0104, 32'h0, 1'b0, rnd_line(), 1'b1);
    run_miss(32'h1FC0_0104, 32'h0000_2040, 1'b1, vb, 1'b1);
    run_miss(32'h0000_2044, 32'h0, 1'b0, rnd_line(), 1'b1);

    // fixed 3-cycle ready stalls, rvalid toggling
    bp_mode = 1;
    run_miss(32'h1FC0_0104, 32'h0, 1'b0, rnd_line(), 1'b0);
    run_miss(32'h1FC0_0104, 32'h0000_2040, 1'b1, vb, 1'b0);

    // early and missing rlast
    bp_mode = 0;
    rlast_mode = 1;
    run_miss(32'h1FC0_0104, 32'h0, 1'b0, rnd_line(), 1'b1);
    rlast_mode = 2;
    run_miss(32'h1FC0_0104, 32'h0, 1'b0, rnd_line(), 1'b1);
    rlast_mode = 0;

    // reset during the write burst, then a fresh clean miss
    tgt = w_total + 5;
    start_miss(32'h1FC0_0100, 32'h7000_0040, 1'b1, rnd_line(), 1'b0);
    t = 0;
    while (w_total < tgt && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) chk("midw_timeout", 1, 0);
    rst = 1;
    @(posedge clk);
    #1;
    flush_exp();
    @(negedge clk);
    check_reset("rst_midw");
    @(posedge clk);
    #1;
    rst = 0;
    run_miss(32'h1FC0_0104, 32'h0, 1'b0, rnd_line(), 1'b1);

    // random traffic over a small set of lines
    bp_mode = 2;
    for (int n = 0; n < 30; n++) begin
      rlast_mode = $urandom_range(0, 2);
      run_miss(32'h8000_0000 | ($urandom_range(0, 15) << 6) | $urandom_range(0, 63),
               32'h8000_0000 | ($urandom_range(0, 15) << 6) | $urandom_range(0, 63),
               1'($urandom), rnd_line(), 1'b0);
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
